rs232_tx: RTL and testbench

//  Serial transmitter that drains bytes from the DMA TX channel onto the RS232 line (8N1, or 8N2).

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_baud_cnt.sv | 34 +++
 rtl/rs232_tx.sv | 134 +++++++++++++
 tb/tb_rs232_tx.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, data width and baud divisor helper.
// Also intended for use by the receiver.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    localparam int DATA_BITS = 8;

    function automatic int bit_cycles(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: Tick marks the last clock of each bit period.
// Clear holds the count at zero so a frame starts on a full bit period.
module uart_baud_cnt #(
    parameter int BIT_CYCLES = 434
) (
    input  logic Clk,
    input  logic Rst,
    input  logic Clear,
    output logic Tick
);

    localparam int CNT_W = $clog2(BIT_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (Clear || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Tick = (cnt_q == LAST);

endmodule

// File: rtl/rs232_tx.sv
// RS232 8N1/8N2 transmitter with a one-byte holding register in front of the shift register,
// so a byte queued during a frame follows it with no idle gap.
module rs232_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115_200,
    parameter int STOP_BITS = 1
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [DATA_BITS-1:0] TX_Data,
    input  logic                 TX_Valid,
    output logic                 TX_Ready,
    output logic                 TD,
    output logic                 Tx_Busy
);

    localparam int BIT_CYCLES = bit_cycles(CLK_FREQ, BAUD_RATE);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    generate
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $error("rs232_tx: STOP_BITS must be 1 or 2");
        end
        if (BIT_CYCLES < 2) begin : g_bad_baud
            $error("rs232_tx: BIT_CYCLES must be at least 2");
        end
    endgenerate

    tx_state_t            state_q, state_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 hold_full_q, hold_full_d;
    logic                 td_q, td_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 tick;

    uart_baud_cnt #(.BIT_CYCLES(BIT_CYCLES)) u_baud (
        .Clk  (Clk),
        .Rst  (Rst),
        .Clear(state_q == IDLE),
        .Tick (tick)
    );

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        shift_d     = shift_q;
        hold_full_d = hold_full_q;
        td_d        = td_q;
        bit_idx_d   = bit_idx_q;
        stop_idx_d  = stop_idx_q;

        // Acceptance needs an empty hold, transfer needs a full one, so they never collide.
        if (TX_Valid && !hold_full_q) begin
            hold_d      = TX_Data;
            hold_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                td_d = 1'b1;
                if (hold_full_q) begin
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
                    state_d     = START;
                    td_d        = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    td_d      = shift_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx_q == LAST_BIT) begin
                        state_d    = STOP;
                        td_d       = 1'b1;
                        stop_idx_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        td_d      = shift_q[bit_idx_q + 3'd1];
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (stop_idx_q == LAST_STOP) begin
                        if (hold_full_q) begin
                            shift_d     = hold_q;
                            hold_full_d = 1'b0;
                            state_d     = START;
                            td_d        = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= IDLE;
            hold_full_q <= 1'b0;
            td_q        <= 1'b1;
            bit_idx_q   <= '0;
            stop_idx_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_full_q <= hold_full_d;
            td_q        <= td_d;
            bit_idx_q   <= bit_idx_d;
            stop_idx_q  <= stop_idx_d;
        end
        hold_q  <= hold_d;
        shift_q <= shift_d;
    end

    assign TX_Ready = ~hold_full_q;
    assign TD       = td_q;
    assign Tx_Busy  = (state_q != IDLE) || hold_full_q;

endmodule

// File: tb/tb_rs232_tx.sv
// Bench for rs232_tx: one instance with one stop bit, one with two, BIT_CYCLES=10.
// Stimulus queues expected frames; a line monitor checks start time and every frame cycle.
module tb_rs232_tx;

    typedef struct {
        logic [7:0] data;
        int         start;
    } frame_t;

    logic       Clk = 1'b0;
    logic [1:0] rst_v = 2'b11;
    logic [1:0] txv_v = 2'b00;
    logic [7:0] txd [2];
    wire        rdy0, rdy1, td0, td1, busy0, busy1;
    logic [1:0] rdy_v, td_v, busy_v;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int line_free [2];
    frame_t q0 [$];
    frame_t q1 [$];

    assign rdy_v  = {rdy1, rdy0};
    assign td_v   = {td1, td0};
    assign busy_v = {busy1, busy0};

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    rs232_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .STOP_BITS(1)) dut0 (
        .Clk(Clk), .Rst(rst_v[0]), .TX_Data(txd[0]), .TX_Valid(txv_v[0]),
        .TX_Ready(rdy0), .TD(td0), .Tx_Busy(busy0)
    );

    rs232_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .STOP_BITS(2)) dut1 (
        .Clk(Clk), .Rst(rst_v[1]), .TX_Data(txd[1]), .TX_Valid(txv_v[1]),
        .TX_Ready(rdy1), .TD(td1), .Tx_Busy(busy1)
    );

    task automatic chk(input string name, input logic ok, input int act, input int req);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    endtask

    function automatic int flen(input int d);
        return (d == 0) ? 100 : 110;
    endfunction

    // Expected line level at cycle p of a frame: start, 8 data bits LSB first, stop.
    function automatic logic exp_bit(input logic [7:0] b, input int p);
        int bi;
        bi = p / 10;
        if (bi == 0) return 1'b0;
        if (bi <= 8) return b[bi-1];
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic send(input int d, input logic [7:0] b, output int st);
        int n;
        logic r;
        frame_t f;
        txd[d]   = b;
        txv_v[d] = 1'b1;
        n = 0;
        forever begin
            r = rdy_v[d];
            tick();
            n++;
            if (r || n > 1000) break;
        end
        txv_v[d] = 1'b0;
        if (!r) begin
            chk("accept_timeout", 1'b0, 0, 1);
            st = -1;
        end else begin
            st = (cyc + 1 > line_free[d]) ? cyc + 1 : line_free[d];
            line_free[d] = st + flen(d);
            f.data  = b;
            f.start = st;
            if (d == 0) q0.push_back(f);
            else q1.push_back(f);
        end
    endtask

    task automatic wait_idle(input int d, output int when);
        int n;
        n = 0;
        while (busy_v[d] !== 1'b0 && n < 2000) begin
            tick();
            n++;
        end
        chk("idle_timeout", busy_v[d] === 1'b0, int'(busy_v[d]), 0);
        when = cyc;
    endtask

    // Line monitor
    initial begin
        logic   in_frame [2];
        int     pos [2];
        int     ferr [2];
        frame_t cur [2];
        frame_t f;
        logic   have;
        for (int d = 0; d < 2; d++) begin
            in_frame[d] = 1'b0;
            pos[d] = 0;
            ferr[d] = 0;
        end
        forever begin
            @(negedge Clk);
            for (int d = 0; d < 2; d++) begin
                if (rst_v[d]) begin
                    in_frame[d] = 1'b0;
                    if (d == 0) q0.delete();
                    else q1.delete();
                end else if (in_frame[d]) begin
                    if (td_v[d] !== exp_bit(cur[d].data, pos[d])) ferr[d]++;
                    pos[d]++;
                    if (pos[d] == flen(d)) begin
                        chk($sformatf("frame_%0d_%02h", d, cur[d].data), ferr[d] == 0, ferr[d], 0);
                        in_frame[d] = 1'b0;
                    end
                end else if (td_v[d] !== 1'b1) begin
                    have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
                    if (!have) begin
                        chk($sformatf("unexpected_start_%0d", d), 1'b0, cyc, -1);
                    end else begin
                        f = (d == 0) ? q0.pop_front() : q1.pop_front();
                        chk($sformatf("start_%0d_%02h", d, f.data), cyc == f.start, cyc, f.start);
                        cur[d] = f;
                        in_frame[d] = 1'b1;
                        pos[d] = 1;
                        ferr[d] = (td_v[d] === 1'b0) ? 0 : 1;
                    end
                end
            end
        end
    end

    initial begin
        int s, s2, s3, fall;
        txd[0] = 8'h00;
        txd[1] = 8'h00;
        line_free[0] = 0;
        line_free[1] = 0;

        // Reset with TX_Valid offered: must be ignored
        txv_v = 2'b11;
        txd[0] = 8'h77;
        repeat (3) tick();
        chk("rst_td", td0 === 1'b1, int'(td0), 1);
        chk("rst_ready", rdy0 === 1'b1, int'(rdy0), 1);
        chk("rst_busy", busy0 === 1'b0, int'(busy0), 0);
        rst_v = 2'b00;
        txv_v = 2'b00;
        repeat (40) tick();
        chk("post_rst_td", td0 === 1'b1, int'(td0), 1);
        chk("post_rst_busy", busy0 === 1'b0, int'(busy0), 0);

        // Single byte and Tx_Busy timing
        send(0, 8'hA5, s);
        chk("busy_queued", busy0 === 1'b1, int'(busy0), 1);
        wait_idle(0, fall);
        chk("busy_fall", fall == s + 100, fall, s + 100);
        repeat (5) tick();

        // Back-to-back, then a byte held while the hold register is full
        send(0, 8'h00, s);
        send(0, 8'hFF, s2);
        chk("ready_low_hold_full", rdy0 === 1'b0, int'(rdy0), 0);
        send(0, 8'h3C, s3);
        wait_idle(0, fall);
        chk("three_frames_end", fall == s + 300, fall, s + 300);
        repeat (5) tick();

        // Reset during DATA bit 3, with a byte waiting in the hold register
        send(0, 8'h5A, s);
        send(0, 8'h99, s2);
        while (cyc < s + 45) tick();
        rst_v[0] = 1'b1;
        tick();
        rst_v[0] = 1'b0;
        line_free[0] = 0;
        chk("midrst_td", td0 === 1'b1, int'(td0), 1);
        chk("midrst_ready", rdy0 === 1'b1, int'(rdy0), 1);
        chk("midrst_busy", busy0 === 1'b0, int'(busy0), 0);
        repeat (300) tick();
        chk("midrst_quiet_busy", busy0 === 1'b0, int'(busy0), 0);

        // Two stop bits, back-to-back
        send(1, 8'h81, s);
        send(1, 8'h42, s2);
        wait_idle(1, fall);
        chk("sb2_end", fall == s + 220, fall, s + 220);

        repeat (20) tick();
        chk("drain_q0", q0.size() == 0, q0.size(), 0);
        chk("drain_q1", q1.size() == 0, q1.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=%0t required=finish", $time);
        $fatal(1, "timeout");
    end

endmodule
